// File: rtl/ffmul_pkg.sv
// rtl/ffmul_pkg.sv - field opcodes, per-field word counts and responder state enum
package ffmul_pkg;

    // Field opcodes carried on op_i alongside the multiplier result
    localparam logic [1:0] FF409 = 2'd0;
    localparam logic [1:0] FF233 = 2'd1;
    localparam logic [1:0] FF193 = 2'd2;
    localparam logic [1:0] FF113 = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rsp_state_t;

    // Number of 32-bit words needed to carry the field (ceil(width/32))
    function automatic logic [3:0] ff_nwords(input logic [1:0] op);
        case (op)
            FF409:   ff_nwords = 4'd13;
            FF233:   ff_nwords = 4'd8;
            FF193:   ff_nwords = 4'd7;
            default: ff_nwords = 4'd4;
        endcase
    endfunction

    // Valid bits in the final 32-bit word (width mod 32)
    function automatic logic [5:0] ff_lastbits(input logic [1:0] op);
        case (op)
            FF409:   ff_lastbits = 6'd25;
            FF233:   ff_lastbits = 6'd9;
            FF193:   ff_lastbits = 6'd1;
            default: ff_lastbits = 6'd17;
        endcase
    endfunction

endpackage

// File: rtl/el2_exu_custom_rsp_wsel.sv
// rtl/el2_exu_custom_rsp_wsel.sv - word slice and last-word masking for the result drain
//
// Purpose: picks word idx out of the captured result and clears the bits of the
//          final word that lie above the active field width.
// Ports:   data - captured result buffer
//          idx  - word index to present
//          op   - field opcode of the captured result
//          word - selected, masked word
module el2_exu_custom_rsp_wsel
    import ffmul_pkg::*;
#(
    parameter int DATA_W = 409,
    parameter int WORD_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        idx,
    input  logic [1:0]        op,
    output logic [WORD_W-1:0] word
);

    // idx is 4 bits, so padding to 16 words keeps every slice in range even
    // when the top word of the widest field runs past DATA_W.
    localparam int PAD_W = 16 * WORD_W;

    logic [PAD_W-1:0]  padded;
    logic [WORD_W-1:0] slice;
    logic [5:0]        nbits;
    logic              is_last;

    always_comb begin
        padded              = '0;
        padded[DATA_W-1:0]  = data;
        slice               = padded[int'(idx) * WORD_W +: WORD_W];
        is_last             = (idx == (ff_nwords(op) - 4'd1));
        nbits               = ff_lastbits(op);
        word                = slice;
        // Only the final word straddles the field boundary; everything above
        // the field width there is stale buffer content and must read as 0.
        if (is_last) begin
            for (int b = 0; b < WORD_W; b++) begin
                if (b >= int'(nbits)) begin
                    word[b] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/el2_exu_custom_rsp.sv
// rtl/el2_exu_custom_rsp.sv - drains a finite-field multiply result as a stream of words
//
// Purpose: captures the multiplier result on its completion pulse and returns it
//          to EXU writeback one WORD_W word at a time under valid/ready.
// Build:   EL2_FFRSP_MSW_FIRST_EN streams most-significant word first (idx counts
//          down to 0); undefined streams least-significant first (idx counts up).
// Ports:   clk, rst (async, active-high)
//          res_valid_i, res_i, op_i, res_ready_o - capture side from ffmul
//          flush_i                               - abort, drops any buffered result
//          word_o, word_idx_o, word_last_o,
//          word_valid_o, word_ready_i            - word stream to writeback
//          busy_o                                - drain in progress
//          overrun_o                             - pulse when a result was dropped
// Note:    ff_nwords/ff_lastbits assume WORD_W = 32; DATA_W must be at least 113.
module el2_exu_custom_rsp
    import ffmul_pkg::*;
#(
    parameter int DATA_W = 409,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid_i,
    input  logic [DATA_W-1:0] res_i,
    input  logic [1:0]        op_i,
    output logic              res_ready_o,
    input  logic              flush_i,
    output logic [WORD_W-1:0] word_o,
    output logic [3:0]        word_idx_o,
    output logic              word_last_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              busy_o,
    output logic              overrun_o
);

    rsp_state_t        state_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        op_q;
    logic [3:0]        idx_q;
    logic              ovr_q;

    logic [3:0]        start_idx;
    logic [3:0]        end_idx;
    logic [3:0]        next_idx;

`ifdef EL2_FFRSP_MSW_FIRST_EN
    // start_idx is used at capture time, so it follows the incoming opcode
    assign start_idx = ff_nwords(op_i) - 4'd1;
    assign end_idx   = 4'd0;
    assign next_idx  = idx_q - 4'd1;
`else
    assign start_idx = 4'd0;
    assign end_idx   = ff_nwords(op_q) - 4'd1;
    assign next_idx  = idx_q + 4'd1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= FF409;
            idx_q   <= 4'd0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
                idx_q   <= 4'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (res_valid_i) begin
                            data_q  <= res_i;
                            op_q    <= op_i;
                            idx_q   <= start_idx;
                            state_q <= SEND;
                        end
                    end
                    SEND: begin
                        // No second buffer: a result arriving mid-drain is lost
                        ovr_q <= res_valid_i;
                        if (word_ready_i) begin
                            if (idx_q == end_idx) begin
                                state_q <= IDLE;
                            end else begin
                                idx_q <= next_idx;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    el2_exu_custom_rsp_wsel #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_wsel (
        .data (data_q),
        .idx  (idx_q),
        .op   (op_q),
        .word (word_o)
    );

    // Held low while rst is asserted so ffmul cannot hand off into a reset block
    assign res_ready_o  = (state_q == IDLE) && !rst;
    assign word_valid_o = (state_q == SEND);
    assign busy_o       = (state_q == SEND);
    assign word_last_o  = (state_q == SEND) && (idx_q == end_idx);
    assign word_idx_o   = idx_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_el2_exu_custom_rsp.sv
// tb/tb_el2_exu_custom_rsp.sv - randomized self-checking bench for el2_exu_custom_rsp
module tb_el2_exu_custom_rsp;
    import ffmul_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         res_valid_i;
    logic [408:0] res_i;
    logic [1:0]   op_i;
    logic         res_ready_o;
    logic         flush_i;
    logic [31:0]  word_o;
    logic [3:0]   word_idx_o;
    logic         word_last_o;
    logic         word_valid_o;
    logic         word_ready_i;
    logic         busy_o;
    logic         overrun_o;

    int n_cmp = 0;
    int n_bad = 0;

    el2_exu_custom_rsp dut (
        .clk          (clk),
        .rst          (rst),
        .res_valid_i  (res_valid_i),
        .res_i        (res_i),
        .op_i         (op_i),
        .res_ready_o  (res_ready_o),
        .flush_i      (flush_i),
        .word_o       (word_o),
        .word_idx_o   (word_idx_o),
        .word_last_o  (word_last_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwidth(input logic [1:0] op);
        case (op)
            FF409:   return 409;
            FF233:   return 233;
            FF193:   return 193;
            default: return 113;
        endcase
    endfunction

    function automatic int nwords_of(input logic [1:0] op);
        return (fwidth(op) + 31) / 32;
    endfunction

    // Word w of the field: result bits at or above the field width read as 0
    function automatic logic [31:0] model_word(input logic [1:0] op, input logic [408:0] d, input int w);
        logic [31:0] r;
        int pos;
        for (int b = 0; b < 32; b++) begin
            pos  = w * 32 + b;
            r[b] = (pos < fwidth(op)) ? d[pos] : 1'b0;
        end
        return r;
    endfunction

    // Index of the k-th word on the stream
    function automatic int stream_idx(input logic [1:0] op, input int k);
`ifdef EL2_FFRSP_MSW_FIRST_EN
        return nwords_of(op) - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic [408:0] rand409();
        logic [415:0] t;
        for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
        return t[408:0];
    endfunction

    // Entered and left at a negedge with the responder idle. mode: 0 always
    // ready, 1 ready pattern 1,0,0,1, 2 random. ovr_at/flush_at: stream
    // position at which to inject a result / a flush (-1 = never).
    task automatic drain(input logic [1:0] op, input logic [408:0] d, input int mode,
                         input int ovr_at, input int flush_at);
        int n, k, cyc;
        bit ovr_pend, ovr_done, rdy;
        n = nwords_of(op);
        chk("cap_ready", {31'd0, res_ready_o}, 32'd1);
        res_valid_i  = 1'b1;
        res_i        = d;
        op_i         = op;
        word_ready_i = 1'b0;
        k = 0; cyc = 0; ovr_pend = 0; ovr_done = 0;
        while (k < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            res_valid_i = 1'b0;
            flush_i     = 1'b0;
            chk("overrun", {31'd0, overrun_o}, {31'd0, ovr_pend});
            ovr_pend = 0;
            chk("valid", {31'd0, word_valid_o}, 32'd1);
            chk("busy", {31'd0, busy_o}, 32'd1);
            chk("ready_in_send", {31'd0, res_ready_o}, 32'd0);
            chk("idx", {28'd0, word_idx_o}, 32'(stream_idx(op, k)));
            chk("word", word_o, model_word(op, d, stream_idx(op, k)));
            chk("last", {31'd0, word_last_o}, {31'd0, (k == n - 1)});
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (k == ovr_at && !ovr_done) begin
                res_valid_i = 1'b1;
                res_i       = rand409();
                op_i        = 2'($urandom_range(0, 3));
                ovr_pend    = 1;
                ovr_done    = 1;
            end
            word_ready_i = rdy;
            if (k == flush_at) begin
                flush_i = 1'b1;
                @(negedge clk);
                flush_i      = 1'b0;
                word_ready_i = 1'b0;
                chk("flush_valid", {31'd0, word_valid_o}, 32'd0);
                chk("flush_idx", {28'd0, word_idx_o}, 32'd0);
                chk("flush_ready", {31'd0, res_ready_o}, 32'd1);
                chk("flush_busy", {31'd0, busy_o}, 32'd0);
                chk("flush_overrun", {31'd0, overrun_o}, 32'd0);
                return;
            end
            if (rdy) k++;
        end
        chk("drain_words", 32'(k), 32'(n));
        if (mode == 0) chk("drain_cycles", 32'(cyc), 32'(n));
        @(negedge clk);
        res_valid_i  = 1'b0;
        word_ready_i = 1'b0;
        chk("end_overrun", {31'd0, overrun_o}, {31'd0, ovr_pend});
        chk("end_valid", {31'd0, word_valid_o}, 32'd0);
        chk("end_ready", {31'd0, res_ready_o}, 32'd1);
        chk("end_busy", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [408:0] d;
        logic [127:0] pat;

        rst          = 1'b1;
        res_valid_i  = 1'b0;
        res_i        = '0;
        op_i         = FF409;
        flush_i      = 1'b0;
        word_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, res_ready_o}, 32'd0);
        chk("rst_valid", {31'd0, word_valid_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, res_ready_o}, 32'd1);
        chk("post_rst_valid", {31'd0, word_valid_o}, 32'd0);
        chk("post_rst_last", {31'd0, word_last_o}, 32'd0);
        chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("post_rst_overrun", {31'd0, overrun_o}, 32'd0);
        chk("post_rst_word", word_o, 32'd0);
        chk("post_rst_idx", {28'd0, word_idx_o}, 32'd0);
        @(negedge clk);

        // FF409, all ones, full throughput
        d = '1;
        drain(FF409, d, 0, -1, -1);

        // FF113 word pattern, bits above 112 all ones
        pat = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        d = '1;
        d[112:0] = pat[112:0];
        drain(FF113, d, 0, -1, -1);

        // FF233 with ready toggling 1,0,0,1
        drain(FF233, rand409(), 1, -1, -1);

        // FF193 flushed at the fourth word, then a clean drain
        drain(FF193, rand409(), 0, -1, 3);
        drain(FF193, rand409(), 0, -1, -1);

        // FF409 with a second result arriving at the sixth word
        drain(FF409, rand409(), 0, 5, -1);

        // Flush and capture together while idle: nothing captured
        res_valid_i = 1'b1;
        flush_i     = 1'b1;
        res_i       = rand409();
        op_i        = FF233;
        @(negedge clk);
        res_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk("idle_flush_valid", {31'd0, word_valid_o}, 32'd0);
        chk("idle_flush_ready", {31'd0, res_ready_o}, 32'd1);
        chk("idle_flush_overrun", {31'd0, overrun_o}, 32'd0);

        // Back-to-back random drains with random backpressure
        for (int i = 0; i < 12; i++) begin
            drain(2'($urandom_range(0, 3)), rand409(), 2,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
        end

        // Reset in the middle of a drain
        res_valid_i  = 1'b1;
        res_i        = rand409();
        op_i         = FF409;
        @(negedge clk);
        res_valid_i  = 1'b0;
        word_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, word_valid_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_ready", {31'd0, res_ready_o}, 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        word_ready_i = 1'b0;
        #1;
        chk("midrst_rel_ready", {31'd0, res_ready_o}, 32'd1);
        chk("midrst_rel_idx", {28'd0, word_idx_o}, 32'd0);
        chk("midrst_rel_word", word_o, 32'd0);
        @(negedge clk);
        drain(FF113, rand409(), 2, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
